// File: rtl/lemon_pkg.sv
// Shared types and constants for the writeback stage: FSM state encoding and load funct3 codes.
package lemon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_aligner.sv
// Combinational load data alignment: selects the byte/halfword lane, extends it,
// and flags misaligned accesses and funct3 codes that are not loads.
module load_aligner #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            bad
);
    import lemon_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = word[{addr_lo[1], 4'b0000} +: 16];
        data     = '0;
        bad      = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data = {{(XLEN-16){half_sel[15]}}, half_sel};
                bad  = addr_lo[0];
            end
            F3_LHU: begin
                data = {{(XLEN-16){1'b0}}, half_sel};
                bad  = addr_lo[0];
            end
            F3_LW: begin
                data = word;
                bad  = (addr_lo != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_writeback.sv
// Writeback stage in front of the register file: retires one instruction per handshake,
// performs the data-memory word read for loads, and drives one write/commit pulse per instruction.
module load_writeback #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int XLEN           = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_wen,
    input  logic                      in_is_load,
    input  logic [2:0]                in_funct3,
    input  logic [XLEN-1:0]           in_result,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [XLEN-1:0]           mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [XLEN-1:0]           mem_resp_data,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd,
    output logic [XLEN-1:0]           rf_wdata,
    output logic                      commit,
    output logic                      load_fault
);
    import lemon_pkg::*;

    wb_state_t                 state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      wen_q, wen_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [XLEN-1:0]           result_q, result_d;
    logic                      fault_q, fault_d;

    logic            accept;
    logic            in_wait;
    logic            in_wb;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr;
    logic [XLEN-1:0] al_data;
    logic            al_bad;

    assign in_wait  = (state_q == WAIT);
    assign in_wb    = (state_q == WB);
    assign in_ready = (state_q == IDLE) || in_wb;
    assign accept   = in_valid && in_ready;

    // One aligner serves both uses: the legality check at accept (IDLE/WB) and data capture in WAIT.
    assign al_funct3 = in_wait ? funct3_q : in_funct3;
    assign al_addr   = in_wait ? result_q[1:0] : in_result[1:0];

    load_aligner #(.XLEN(XLEN)) u_load_aligner (
        .funct3  (al_funct3),
        .addr_lo (al_addr),
        .word    (mem_resp_data),
        .data    (al_data),
        .bad     (al_bad)
    );

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        funct3_d = funct3_q;
        result_d = result_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE, WB: begin
                state_d = IDLE;
                if (accept) begin
                    rd_d     = in_rd;
                    wen_d    = in_wen;
                    funct3_d = in_funct3;
                    result_d = in_result;
                    fault_d  = in_is_load && al_bad;
                    state_d  = (in_is_load && !al_bad) ? REQ : WB;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The address is no longer needed once data arrives, so result holds the load data.
                if (mem_resp_valid) begin
                    result_d = al_data;
                    state_d  = WB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            wen_q    <= 1'b0;
            funct3_q <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wen_q    <= wen_d;
            funct3_q <= funct3_d;
            result_q <= result_d;
            fault_q  <= fault_d;
        end
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = mem_req_valid ? {result_q[XLEN-1:2], 2'b00} : '0;

    // Writes to x0 are dropped here so the register file never sees one.
    assign commit     = in_wb;
    assign rf_wen     = in_wb && wen_q && (rd_q != '0) && !fault_q;
    assign rf_rd      = in_wb ? rd_q : '0;
    assign rf_wdata   = in_wb ? result_q : '0;
    assign load_fault = in_wb && fault_q;

endmodule
